// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage of a 5-stage MIPS pipeline. Owns the PC and talks
// to instruction memory over a req/ack handshake with at most one request in
// flight. It applies branch/jump redirects from decode and drives the IF/ID
// pipeline register. Stall and flush are supported.
//
// States:
//   FETCH - request at pc, consume the ack.
//   HOLD  - a word arrived while stalled; it is parked in a one-entry buffer
//           and no new request is issued.
//   DRAIN - a redirect hit while a request was in flight; wait for its ack
//           and throw the data away.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   pcsrc, baddr      branch taken / target (branch beats jump)
//   jump, jaddr       jump taken / target
//   if_flush          squash the word entering IF/ID this cycle
//   stall             hold IF/ID and PC
//   imem_req/addr     fetch request and word-aligned address
//   imem_rdata/ack    fetched word and its single-cycle response strobe
//   pc_out, ins_out   IF/ID: address of delivered word + 4, delivered word
//   valid_out         IF/ID holds a real instruction (0 = bubble)
//
// Optional feature (define IF_PERF_CNT_EN):
//   bubble_cnt        saturating count of cycles in which IF/ID loads a bubble
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcsrc,
    input  logic [31:0] baddr,
    input  logic        jump,
    input  logic [31:0] jaddr,
    input  logic        if_flush,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] pc_out,
    output logic [31:0] ins_out,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] bubble_cnt,
`endif
    output logic        valid_out
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Redirect targets must be word addresses; the two low bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] drain_addr_r, drain_addr_s;
    logic [31:0] buf_pc_r, buf_pc_s;
    logic [31:0] buf_ins_r, buf_ins_s;
    logic [31:0] ifid_pc_r, ifid_pc_s;
    logic [31:0] ifid_ins_r, ifid_ins_s;
    logic        ifid_valid_r, ifid_valid_s;
    logic        bubble_s;
    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] pc_plus4_s;

    assign redirect_s = pcsrc | jump;
    assign target_s   = word_align(pcsrc ? baddr : jaddr);
    assign pc_plus4_s = pc_r + 32'd4;

    // In DRAIN the outstanding request keeps its original address even though
    // pc_r already points at the redirect target.
    assign imem_req  = rst & (state_r != ST_HOLD);
    assign imem_addr = (state_r == ST_DRAIN) ? drain_addr_r : pc_r;

    assign pc_out    = ifid_pc_r;
    assign ins_out   = ifid_ins_r;
    assign valid_out = ifid_valid_r;

    // Next-state, PC, hold-buffer and IF/ID decisions.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        drain_addr_s = drain_addr_r;
        buf_pc_s     = buf_pc_r;
        buf_ins_s    = buf_ins_r;
        ifid_pc_s    = ifid_pc_r;
        ifid_ins_s   = ifid_ins_r;
        ifid_valid_s = ifid_valid_r;
        bubble_s     = 1'b0;

        case (state_r)
            ST_FETCH: begin
                if (redirect_s) begin
                    pc_s     = target_s;
                    bubble_s = 1'b1;
                    if (imem_ack) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s      = ST_DRAIN;
                        drain_addr_s = pc_r;
                    end
                end else if (if_flush) begin
                    // Word is discarded (if any); pc_r is kept so it is refetched.
                    bubble_s = 1'b1;
                end else if (imem_ack) begin
                    pc_s = pc_plus4_s;
                    if (stall) begin
                        buf_pc_s  = pc_plus4_s;
                        buf_ins_s = imem_rdata;
                        state_s   = ST_HOLD;
                    end else begin
                        ifid_pc_s    = pc_plus4_s;
                        ifid_ins_s   = imem_rdata;
                        ifid_valid_s = 1'b1;
                    end
                end else if (!stall) begin
                    bubble_s = 1'b1;
                end else begin
                    state_s = ST_FETCH;
                end
            end

            ST_HOLD: begin
                if (redirect_s) begin
                    pc_s     = target_s;
                    bubble_s = 1'b1;
                    state_s  = ST_FETCH;
                end else if (if_flush) begin
                    // pc_r already moved past the parked word; step back to refetch it.
                    pc_s     = pc_r - 32'd4;
                    bubble_s = 1'b1;
                    state_s  = ST_FETCH;
                end else if (!stall) begin
                    ifid_pc_s    = buf_pc_r;
                    ifid_ins_s   = buf_ins_r;
                    ifid_valid_s = 1'b1;
                    state_s      = ST_FETCH;
                end else begin
                    state_s = ST_HOLD;
                end
            end

            ST_DRAIN: begin
                if (imem_ack) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_DRAIN;
                end
                if (redirect_s) begin
                    pc_s = target_s;
                end else begin
                    pc_s = pc_r;
                end
                if (redirect_s || if_flush || !stall) begin
                    bubble_s = 1'b1;
                end else begin
                    bubble_s = 1'b0;
                end
            end

            default: begin
                state_s  = ST_FETCH;
                bubble_s = 1'b1;
            end
        endcase

        // A bubble keeps pc_out and replaces the word with the NOP.
        if (bubble_s) begin
            ifid_ins_s   = NOP_INS;
            ifid_valid_s = 1'b0;
        end else begin
            bubble_s = 1'b0;
        end
    end

    // State, PC, buffer and IF/ID registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_FETCH;
            pc_r         <= RESET_PC;
            drain_addr_r <= 32'h0000_0000;
            buf_pc_r     <= 32'h0000_0000;
            buf_ins_r    <= 32'h0000_0000;
            ifid_pc_r    <= 32'h0000_0000;
            ifid_ins_r   <= NOP_INS;
            ifid_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            drain_addr_r <= drain_addr_s;
            buf_pc_r     <= buf_pc_s;
            buf_ins_r    <= buf_ins_s;
            ifid_pc_r    <= ifid_pc_s;
            ifid_ins_r   <= ifid_ins_s;
            ifid_valid_r <= ifid_valid_s;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] bubble_cnt_r;

    // Saturating count of cycles in which IF/ID loads a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt_r <= 32'h0000_0000;
        end else if (bubble_s && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
            bubble_cnt_r <= bubble_cnt_r + 32'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the decode stage.
- Owns the PC register and issues requests to instruction memory over a req/ack handshake.
- Applies branch and jump redirects coming back from decode.
- Drives the IF/ID pipeline register (pc_out = PC+4 of the fetched word, ins_out = fetched word), with stall and flush support.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset. Bits [1:0] must be 0.
- NOP_INS, 32'h0000_0000, instruction word inserted into IF/ID for bubbles.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (negedge rst); one clock domain.
- pcsrc  in  1  branch taken, from decode.
- baddr  in  32  branch target, from decode.
- jump  in  1  jump taken, from decode.
- jaddr  in  32  jump target, from decode.
- if_flush  in  1  squash the instruction entering IF/ID this cycle.
- stall  in  1  hazard hold: IF/ID and PC must not advance.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (word aligned).
- imem_rdata  in  32  fetched word; valid only when imem_ack=1.
- imem_ack  in  1  single-cycle response strobe for the outstanding request.
- pc_out  out  32  IF/ID: address of the delivered instruction + 4.
- ins_out  out  32  IF/ID: delivered instruction.
- valid_out  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (async, rst=0):
  - pc_q=RESET_PC, state=FETCH.
  - pc_out=0, ins_out=NOP_INS, valid_out=0.
  - Hold buffer cleared; imem_req=0 while rst=0.
- Handshake:
  - imem_req=1 in FETCH and DRAIN; imem_addr=pc_q in FETCH, old address in DRAIN.
  - Once imem_req is asserted, req and addr stay stable until the ack cycle.
  - At most one request outstanding. Data is taken in the ack cycle (zero-wait memory acks the same cycle).
- Redirect:
  - redirect = pcsrc | jump. Target = pcsrc ? baddr : jaddr (branch has priority).
  - target[1:0] is forced to 00.
- FSM states: FETCH, HOLD, DRAIN.
- FETCH, evaluated in priority order:
  1. redirect & ack: discard rdata; pc_q<=target; IF/ID<=bubble; stay FETCH.
  2. redirect & !ack: pc_q<=target; IF/ID<=bubble; ->DRAIN.
  3. if_flush & ack: discard rdata; pc_q unchanged (refetch); IF/ID<=bubble.
  4. ack & !stall: IF/ID<={pc_q+4, rdata, 1}; pc_q<=pc_q+4.
  5. ack & stall: buffer<={pc_q+4, rdata}; pc_q<=pc_q+4; IF/ID holds; ->HOLD.
  6. !ack & !stall: IF/ID<=bubble (pc_out holds, ins_out=NOP_INS, valid_out=0).
  7. !ack & stall: IF/ID holds.
- HOLD (imem_req=0):
  - redirect: drop buffer; pc_q<=target; IF/ID<=bubble; ->FETCH.
  - if_flush: drop buffer; pc_q<=pc_q-4; IF/ID<=bubble; ->FETCH.
  - !stall: IF/ID<={buffer,1}; ->FETCH.
  - stall: hold.
- DRAIN:
  - Waits for the stale ack and discards it, then ->FETCH.
  - IF/ID loads bubble unless stall.
  - Another redirect in DRAIN overwrites pc_q (last wins).
- Flush/redirect overrides stall: IF/ID is bubbled even when stall=1.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0.
- Throughput: 1 instruction/cycle with zero-wait memory and no hazards. Redirect penalty is 1 bubble (plus drain wait if a request is pending).

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds output bubble_cnt (32 bits).
  - Increments on every cycle in which IF/ID loads a bubble (not held by stall). Saturates at 32'hFFFF_FFFF.
  - Async reset to 0.
- Undefined: the port and counter are absent; no other behaviour changes.

Test Plan:
- Reset with RESET_PC=0, zero-wait memory, release rst -> valid_out=1 from the 2nd posedge; pc_out sequence 4,8,12; ins_out matches mem[0],mem[1],mem[2].
- Memory with 2 wait states -> each instruction is preceded by 2 bubbles (valid_out=0, ins_out=NOP_INS); imem_addr stable during wait.
- stall=1 for 3 cycles during ack at pc_q=0x10 -> HOLD, imem_req=0; after release IF/ID = {0x14, mem[4], 1}; next fetch at 0x14.
- pcsrc=1, baddr=0x40 while a 3-wait request to 0x20 is pending -> DRAIN; stale data discarded; next request at 0x40; no instruction from 0x20 ever has valid_out=1.
- pcsrc=1 (baddr=0x80) and jump=1 (jaddr=0x100) in the same cycle with stall=1 -> bubble loaded; next fetch at 0x80.
- RESET_PC=32'hFFFF_FFFC -> first pc_out=0, next fetch address 0; assert rst mid-wait -> all outputs back to reset values immediately.
